// File: rtl/pic_ram_writer.sv
// pic_ram_writer: loads a 100x100 RGB565 picture into the display RAM from a
// UART byte stream. A sync byte starts a frame, byte pairs (high first) become
// pixels written at sequential addresses, and pic_ready flags a complete frame.
// Optional trailing XOR checksum check: define PIC_LOAD_CHECKSUM_EN.
module pic_ram_writer #(
  parameter logic [9:0]  H_PIC     = 10'd100,
  parameter logic [9:0]  V_PIC     = 10'd100,
  parameter logic [13:0] ADR_MAX   = 14'd9999,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter logic [19:0] TIMEOUT   = 20'd250000
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_flag,
  output logic        wr_en,
  output logic [13:0] wr_addr,
  output logic [15:0] wr_data,
  output logic        busy,
  output logic        pic_ready,
  output logic        load_err
);

  if (ADR_MAX != 14'(H_PIC * V_PIC - 1)) begin : g_bad_adr_max
    $error("ADR_MAX must equal H_PIC*V_PIC-1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV_HI,
    S_RECV_LO,
`ifdef PIC_LOAD_CHECKSUM_EN
    S_CHECK,
`endif
    S_DONE
  } state_t;

  state_t      r_state, w_state;
  logic [7:0]  r_hi, w_hi;
  logic [13:0] r_addr, w_addr;
  logic [19:0] r_tmo, w_tmo;
  logic        r_wr_en, w_wr_en;
  logic [13:0] r_wr_addr, w_wr_addr;
  logic [15:0] r_wr_data, w_wr_data;
  logic        r_busy, w_busy;
  logic        r_pic_ready, w_pic_ready;
  logic        r_load_err, w_load_err;
  logic        w_expire;
`ifdef PIC_LOAD_CHECKSUM_EN
  logic [7:0]  r_csum, w_csum;
`endif

  assign wr_en     = r_wr_en;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;
  assign busy      = r_busy;
  assign pic_ready = r_pic_ready;
  assign load_err  = r_load_err;

  // A byte arriving in the expiry cycle takes priority over the timeout.
  assign w_expire = (r_tmo == TIMEOUT - 20'd1) && !rx_flag;

  // State register and all registered datapath/outputs.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state     <= S_IDLE;
      r_hi        <= '0;
      r_addr      <= '0;
      r_tmo       <= '0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_busy      <= 1'b0;
      r_pic_ready <= 1'b0;
      r_load_err  <= 1'b0;
`ifdef PIC_LOAD_CHECKSUM_EN
      r_csum      <= '0;
`endif
    end else begin
      r_state     <= w_state;
      r_hi        <= w_hi;
      r_addr      <= w_addr;
      r_tmo       <= w_tmo;
      r_wr_en     <= w_wr_en;
      r_wr_addr   <= w_wr_addr;
      r_wr_data   <= w_wr_data;
      r_busy      <= w_busy;
      r_pic_ready <= w_pic_ready;
      r_load_err  <= w_load_err;
`ifdef PIC_LOAD_CHECKSUM_EN
      r_csum      <= w_csum;
`endif
    end
  end

  // Next-state, pixel assembly, timeout and status flag logic.
  always_comb begin
    w_state     = r_state;
    w_hi        = r_hi;
    w_addr      = r_addr;
    w_tmo       = '0;
    w_wr_en     = 1'b0;
    w_wr_addr   = r_wr_addr;
    w_wr_data   = r_wr_data;
    w_busy      = r_busy;
    w_pic_ready = r_pic_ready;
    w_load_err  = 1'b0;
`ifdef PIC_LOAD_CHECKSUM_EN
    w_csum      = r_csum;
`endif
    unique case (r_state)
      S_IDLE: begin
        if (rx_flag && (rx_data == SYNC_BYTE)) begin
          w_state     = S_RECV_HI;
          w_pic_ready = 1'b0;
          w_addr      = '0;
          w_busy      = 1'b1;
`ifdef PIC_LOAD_CHECKSUM_EN
          w_csum      = '0;
`endif
        end
      end
      S_RECV_HI: begin
        w_tmo = rx_flag ? '0 : r_tmo + 20'd1;
        if (rx_flag) begin
          w_hi    = rx_data;
          w_state = S_RECV_LO;
`ifdef PIC_LOAD_CHECKSUM_EN
          w_csum  = r_csum ^ rx_data;
`endif
        end else if (w_expire) begin
          w_tmo      = '0;
          w_load_err = 1'b1;
          w_busy     = 1'b0;
          w_state    = S_IDLE;
        end
      end
      S_RECV_LO: begin
        w_tmo = rx_flag ? '0 : r_tmo + 20'd1;
        if (rx_flag) begin
          w_wr_en   = 1'b1;
          w_wr_addr = r_addr;
          w_wr_data = {r_hi, rx_data};
`ifdef PIC_LOAD_CHECKSUM_EN
          w_csum    = r_csum ^ rx_data;
`endif
          if (r_addr == ADR_MAX) begin
            w_addr  = '0;
`ifdef PIC_LOAD_CHECKSUM_EN
            w_state = S_CHECK;
`else
            w_state = S_DONE;
`endif
          end else begin
            w_addr  = r_addr + 14'd1;
            w_state = S_RECV_HI;
          end
        end else if (w_expire) begin
          w_tmo      = '0;
          w_load_err = 1'b1;
          w_busy     = 1'b0;
          w_state    = S_IDLE;
        end
      end
`ifdef PIC_LOAD_CHECKSUM_EN
      S_CHECK: begin
        w_tmo = rx_flag ? '0 : r_tmo + 20'd1;
        if (rx_flag) begin
          if (rx_data == r_csum) begin
            w_state = S_DONE;
          end else begin
            w_load_err = 1'b1;
            w_busy     = 1'b0;
            w_state    = S_IDLE;
          end
        end else if (w_expire) begin
          w_tmo      = '0;
          w_load_err = 1'b1;
          w_busy     = 1'b0;
          w_state    = S_IDLE;
        end
      end
`endif
      S_DONE: begin
        w_pic_ready = 1'b1;
        w_busy      = 1'b0;
        w_state     = S_IDLE;
      end
      default: w_state = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_pic_ram_writer.sv
// Directed bench for pic_ram_writer; TIMEOUT is shortened to keep runs short.
// Follows PIC_LOAD_CHECKSUM_EN the same way the design does.
module tb_pic_ram_writer;

  localparam logic [19:0] TMO = 20'd64;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_flag = 1'b0;
  logic        wr_en;
  logic [13:0] wr_addr;
  logic [15:0] wr_data;
  logic        busy;
  logic        pic_ready;
  logic        load_err;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [7:0]  csum;
  logic [15:0] pix;

  pic_ram_writer #(.TIMEOUT(TMO)) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .rx_data   (rx_data),
    .rx_flag   (rx_flag),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .pic_ready (pic_ready),
    .load_err  (load_err)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Present one byte for exactly one rising edge; returns 1 time unit after it.
  task automatic strobe(input logic [7:0] b);
    @(negedge sys_clk);
    rx_flag = 1'b1;
    rx_data = b;
    @(posedge sys_clk);
    #1;
    rx_flag = 1'b0;
  endtask

  task automatic send_pixel(input string tag, input logic [15:0] p, input logic [13:0] a);
    strobe(p[15:8]);
    chk({tag, "_hi_wr_en"}, 32'(wr_en), 32'd0);
    strobe(p[7:0]);
    chk({tag, "_wr_en"}, 32'(wr_en), 32'd1);
    chk({tag, "_wr_addr"}, 32'(wr_addr), 32'(a));
    chk({tag, "_wr_data"}, 32'(wr_data), 32'(p));
  endtask

  // Called right after the last byte edge; expects load_err TMO edges later.
  task automatic expect_timeout(input string tag);
    for (int unsigned j = 1; j < 32'(TMO); j++) begin
      tick();
      chk({tag, "_no_err_early"}, 32'(load_err), 32'd0);
    end
    tick();
    chk({tag, "_load_err"}, 32'(load_err), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_pic_ready"}, 32'(pic_ready), 32'd0);
    tick();
    chk({tag, "_load_err_once"}, 32'(load_err), 32'd0);
  endtask

  task automatic send_full_frame(output logic [7:0] cs);
    logic [15:0] p;
    cs = '0;
    for (int unsigned i = 0; i < 10000; i++) begin
      p = 16'hA5A5 ^ 16'(i * 3);
      cs = cs ^ p[15:8] ^ p[7:0];
      send_pixel("frame", p, 14'(i));
    end
  endtask

  initial begin
    // Reset values
    tick(); tick();
    @(negedge sys_clk);
    sys_rst = 1'b0;
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pic_ready", 32'(pic_ready), 32'd0);
    chk("rst_load_err", 32'(load_err), 32'd0);

    // Bytes without sync are ignored
    strobe(8'h12);
    chk("nosync1_wr_en", 32'(wr_en), 32'd0);
    strobe(8'h34);
    chk("nosync2_wr_en", 32'(wr_en), 32'd0);
    tick();
    chk("nosync_wr_en", 32'(wr_en), 32'd0);
    chk("nosync_busy", 32'(busy), 32'd0);
    chk("nosync_pic_ready", 32'(pic_ready), 32'd0);

    // Two pixels after sync
    strobe(8'hA5);
    chk("sync_busy", 32'(busy), 32'd1);
    send_pixel("px0", 16'hF800, 14'd0);
    send_pixel("px1", 16'h07E0, 14'd1);
    tick();
    chk("px1_wr_en_one_cycle", 32'(wr_en), 32'd0);
    chk("px1_busy", 32'(busy), 32'd1);
    // Idle from here: 1 cycle already elapsed since last byte
    for (int unsigned j = 2; j < 32'(TMO); j++) begin
      tick();
      chk("to0_no_err_early", 32'(load_err), 32'd0);
    end
    tick();
    chk("to0_load_err", 32'(load_err), 32'd1);
    chk("to0_busy", 32'(busy), 32'd0);
    tick();
    chk("to0_load_err_once", 32'(load_err), 32'd0);

    // Partial frame of 501 data bytes, then timeout
    strobe(8'hA5);
    for (int unsigned i = 0; i < 250; i++) begin
      pix = 16'h1357 + 16'(i);
      send_pixel("part", pix, 14'(i));
    end
    strobe(8'h99);
    chk("part_odd_wr_en", 32'(wr_en), 32'd0);
    expect_timeout("to1");

    // Restart at address 0, then reset mid-frame
    strobe(8'hA5);
    send_pixel("restart", 16'h1122, 14'd0);
    strobe(8'h33);
    @(negedge sys_clk);
    sys_rst = 1'b1;
    tick();
    chk("midrst_wr_en", 32'(wr_en), 32'd0);
    chk("midrst_wr_addr", 32'(wr_addr), 32'd0);
    chk("midrst_wr_data", 32'(wr_data), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_pic_ready", 32'(pic_ready), 32'd0);
    chk("midrst_load_err", 32'(load_err), 32'd0);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    strobe(8'h44);
    strobe(8'h55);
    chk("postrst_wr_en", 32'(wr_en), 32'd0);
    chk("postrst_busy", 32'(busy), 32'd0);

    // Full frame; first pixel is A5A5 so the sync value appears as data
    strobe(8'hA5);
    send_full_frame(csum);
`ifdef PIC_LOAD_CHECKSUM_EN
    chk("last_busy", 32'(busy), 32'd1);
    strobe(csum);
    chk("csum_load_err", 32'(load_err), 32'd0);
`endif
    chk("done_entry_pic_ready", 32'(pic_ready), 32'd0);
    chk("done_entry_busy", 32'(busy), 32'd1);
    tick();
    chk("done_pic_ready", 32'(pic_ready), 32'd1);
    chk("done_busy", 32'(busy), 32'd0);
    chk("done_wr_en", 32'(wr_en), 32'd0);
    chk("done_load_err", 32'(load_err), 32'd0);

    // Trailing byte ignored in IDLE
    strobe(8'h5C);
    chk("trail_wr_en", 32'(wr_en), 32'd0);
    chk("trail_busy", 32'(busy), 32'd0);
    chk("trail_pic_ready", 32'(pic_ready), 32'd1);

    // New sync clears pic_ready
    strobe(8'hA5);
    chk("resync_pic_ready", 32'(pic_ready), 32'd0);
    chk("resync_busy", 32'(busy), 32'd1);
`ifdef PIC_LOAD_CHECKSUM_EN
    send_full_frame(csum);
    strobe(csum ^ 8'h01);
    chk("badcs_load_err", 32'(load_err), 32'd1);
    chk("badcs_busy", 32'(busy), 32'd0);
    chk("badcs_pic_ready", 32'(pic_ready), 32'd0);
    tick();
    chk("badcs_load_err_once", 32'(load_err), 32'd0);
    chk("badcs_pic_ready_low", 32'(pic_ready), 32'd0);
`else
    expect_timeout("to2");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pic_ram_writer.md
# pic_ram_writer

Loader that fills the 100×100 RGB565 picture RAM read by the VGA picture generator. It takes a byte stream from the UART receiver (one-cycle `rx_flag` strobe per byte), waits for a sync byte, and assembles byte pairs into 16-bit pixels. It issues one RAM write per pixel at sequential addresses and raises `pic_ready` once a full frame has been loaded, so the display can gate picture output on it. It is the writer side of the picture memory that the display path reads.

## Interface
Parameters:
- `H_PIC`, 10'd100: picture width in pixels.
- `V_PIC`, 10'd100: picture height in pixels.
- `ADR_MAX`, 14'd9999: last RAM address, equal to H_PIC*V_PIC-1.
- `SYNC_BYTE`, 8'hA5: frame start marker.
- `TIMEOUT`, 20'd250000: idle cycles allowed between bytes inside a frame (10 ms at 25 MHz).

Ports:
- `sys_clk`, in, 1: system clock; all logic is on its rising edge.
- `sys_rst`, in, 1: one clock; reset is synchronous and active-high.
- `rx_data`, in, 8: received byte, valid only while `rx_flag` is high.
- `rx_flag`, in, 1: one-cycle byte-valid strobe.
- `wr_en`, out, 1: RAM write enable, one-cycle pulse per pixel.
- `wr_addr`, out, 14: RAM write address.
- `wr_data`, out, 16: RGB565 pixel to write.
- `busy`, out, 1: high while a frame is being received.
- `pic_ready`, out, 1: high when a complete, valid frame is in RAM.
- `load_err`, out, 1: one-cycle pulse when a frame is aborted or rejected.

## Operation
- Reset values: all outputs 0, state IDLE, internal address counter 0, timeout counter 0, checksum 0.
- IDLE:
  - `rx_flag` with `rx_data==SYNC_BYTE` → RECV_HI. This clears `pic_ready`, the address counter and the checksum, and sets `busy`.
  - Any other byte is ignored.
- RECV_HI: on `rx_flag`, latch `rx_data` as pixel bits [15:8] → RECV_LO. Byte order is high byte first.
- RECV_LO: on `rx_flag`, present the pixel and pulse `wr_en`:
  - `wr_data = {hi, rx_data}`; `wr_addr` = current address counter.
  - If the counter is below ADR_MAX: increment it → RECV_HI.
  - If the counter equals ADR_MAX: counter wraps to 0 → CHECK when checksum is compiled in, otherwise DONE.
- CHECK: described under Configuration.
- DONE: lasts one cycle. Sets `pic_ready`, clears `busy` → IDLE.
- Inside a frame, a byte equal to SYNC_BYTE is treated as pixel data, never as a resync.
- Timeout:
  - The counter runs in RECV_HI, RECV_LO and CHECK and clears on every `rx_flag`.
  - When it reaches TIMEOUT-1 with `rx_flag` low: pulse `load_err`, clear `busy` → IDLE. `pic_ready` stays 0; the partial frame remains in RAM but is flagged invalid.
  - If `rx_flag` and expiry fall in the same cycle, the byte wins and no error is raised.
- Checksum: XOR of all 2×H_PIC×V_PIC data bytes. The sync byte is excluded.

## Timing
- `wr_en`, `wr_addr` and `wr_data` are registered. They are valid in the cycle after the `rx_flag` of the low byte, with `wr_en` high for exactly that one cycle.
- `pic_ready` rises 2 cycles after the final `rx_flag` of a frame: DONE is entered, then the flag registers.
- `pic_ready` falls in the cycle after a sync byte is accepted in IDLE.
- `sys_rst` mid-frame: the next cycle returns to IDLE with all outputs 0, and no `load_err` is raised.
- Back-to-back strobes on consecutive cycles are supported. One byte per cycle is the maximum rate.

## Configuration
- Macro `PIC_LOAD_CHECKSUM_EN`.
- Defined:
  - After the last pixel the block enters CHECK and waits for one trailing byte.
  - Byte equals the running XOR → DONE.
  - Byte differs → pulse `load_err`, clear `busy`, `pic_ready` stays 0 → IDLE.
- Undefined:
  - No CHECK state and no checksum register.
  - The last pixel goes straight to DONE, and any trailing byte is ignored in IDLE.

## Test plan
- Reset, then send 0x12 and 0x34 without sync → no `wr_en`; `busy` = 0, `pic_ready` = 0.
- Send A5, F8, 00, 07, E0 → writes addr 0 = 16'hF800 and addr 1 = 16'h07E0, each `wr_en` one cycle after the second byte of its pair; `busy` = 1.
- Full frame of 20000 data bytes (plus a correct checksum byte if enabled) → exactly 10000 writes at addresses 0..9999, then `pic_ready` = 1 and `busy` = 0.
- Stop after 501 data bytes and wait TIMEOUT cycles → one `load_err` pulse, `pic_ready` = 0, IDLE; a following A5 restarts at addr 0.
- With `PIC_LOAD_CHECKSUM_EN`, send a full frame with a wrong checksum → `load_err` pulse and `pic_ready` = 0.
- Assert `sys_rst` mid-frame → all outputs 0 next cycle; a 0xA5 byte fed as data inside a frame is written as pixel data, not treated as a resync.
